clk_cfg_apb_master: RTL

CLK_CFG_APB_MASTER -- requirements
Module: clk_cfg_apb_master

---
 rtl/clk_cfg_pkg.sv | 34 +++
 rtl/clk_cfg_apb_master.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/clk_cfg_pkg.sv
// clk_cfg_pkg -- shared definitions for the clock-configuration APB path.
// Holds the target-select encoding, the register offsets of the divider
// registers inside the clock-control block (also used by the slave side),
// the master FSM state encoding and an offset lookup helper.
package clk_cfg_pkg;

  typedef enum logic [1:0] {
    CLK_CFG_SOC     = 2'd0,
    CLK_CFG_CLUSTER = 2'd1,
    CLK_CFG_PERIPH  = 2'd2,
    CLK_CFG_INVALID = 2'd3
  } clk_cfg_sel_e;

  localparam logic [11:0] CLK_CFG_SOC_OFFS     = 12'hF00;
  localparam logic [11:0] CLK_CFG_CLUSTER_OFFS = 12'hF08;
  localparam logic [11:0] CLK_CFG_PERIPH_OFFS  = 12'hF10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } clk_cfg_state_e;

  function automatic logic [11:0] clk_cfg_offset(input logic [1:0] sel);
    case (sel)
      CLK_CFG_SOC:     clk_cfg_offset = CLK_CFG_SOC_OFFS;
      CLK_CFG_CLUSTER: clk_cfg_offset = CLK_CFG_CLUSTER_OFFS;
      CLK_CFG_PERIPH:  clk_cfg_offset = CLK_CFG_PERIPH_OFFS;
      default:         clk_cfg_offset = 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/clk_cfg_apb_master.sv
// clk_cfg_apb_master -- turns single divider read/write commands into one
// APB transfer to the clock-control block and returns a response.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   req_valid_i/req_ready_o       command handshake (ready only in IDLE)
//   req_write_i, req_sel_i        1=write/0=read, target (3 = invalid)
//   req_wdata_i                   divider value for writes
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_rdata_o, rsp_err_o        read value (0 on write/error), error flag
//   paddr_o, psel_o, penable_o,
//   pwrite_o, pwdata_o            APB request
//   pready_i, pslverr_i, prdata_i APB completion
//
// Build option
//   CLK_CFG_APB_TIMEOUT_EN  abort ACCESS after TIMEOUT_CYCLES cycles without
//                           pready_i and answer with rsp_err_o = 1.
module clk_cfg_apb_master
  import clk_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h1A10_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_sel_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic        pready_i,
  input  logic        pslverr_i,
  input  logic [31:0] prdata_i
);

  clk_cfg_state_e state_q, state_d;

  logic        write_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        err_q;

  logic accept;
  logic timeout;

  assign accept = req_valid_i && req_ready_o;

  // Only the divider byte is meaningful on the read bus.
  logic unused_prdata;
  assign unused_prdata = ^prdata_i[31:8];

`ifdef CLK_CFG_APB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;

  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that still has no pready_i,
  // so the bus drops in the following cycle.
  assign timeout = (state_q == ST_ACCESS) && !pready_i && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                to_cnt_q <= '0;
    else if (state_q == ST_SETUP)               to_cnt_q <= '0;
    else if (state_q == ST_ACCESS && !pready_i) to_cnt_q <= to_cnt_q + 16'd1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (req_sel_i == CLK_CFG_INVALID) ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready_i || timeout) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Captured command and response. pready_i is only looked at in ACCESS,
  // so a late completion after a timeout cannot disturb the held response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= req_write_i;
      wdata_q <= req_wdata_i;
      addr_q  <= (req_sel_i == CLK_CFG_INVALID) ? 32'h0
                 : BASE_ADDR + {20'h0, clk_cfg_offset(req_sel_i)};
      rdata_q <= '0;
      err_q   <= (req_sel_i == CLK_CFG_INVALID);
    end else if (state_q == ST_ACCESS) begin
      if (pready_i) begin
        err_q   <= pslverr_i;
        rdata_q <= (write_q || pslverr_i) ? 8'h00 : prdata_i[7:0];
      end else if (timeout) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  // Output logic. req_ready_o is gated by reset so it reads 0 while held.
  always_comb begin
    req_ready_o = rst_ni && (state_q == ST_IDLE);
    psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    penable_o   = (state_q == ST_ACCESS);
    rsp_valid_o = (state_q == ST_RESP);
    paddr_o     = addr_q;
    pwrite_o    = write_q;
    pwdata_o    = {24'h0, wdata_q};
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

endmodule
